// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types and defaults for the I/D memory port arbiter.
//   - state_t : arbiter FSM states (IDLE -> BUSY -> DONE -> IDLE)
//   - owner_t : which cache currently owns the memory port
//   - ADDR_W_DEF / DATA_W_DEF : default line address / line data widths
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 28;   // byte address bits [31:4]
    localparam int DATA_W_DEF = 128;  // one cache line

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // The requester that did not get the previous grant.
    function automatic owner_t other_owner(input owner_t owner);
        return (owner == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
//   Combinational two-way picker between the I-cache and the D-cache.
//   RR_EN=1: on a tie the requester that was not granted last time wins.
//   RR_EN=0: on a tie the D-cache always wins.
// Ports
//   i_req_ic   in   I-cache is requesting (read or write)
//   i_req_dc   in   D-cache is requesting (read or write)
//   i_last     in   owner of the most recent grant
//   o_winner   out  chosen owner; only meaningful while o_any=1
//   o_any      out  at least one requester is active
// -----------------------------------------------------------------------------
module rr_pick2
    import mem_port_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic   i_req_ic,
    input  logic   i_req_dc,
    input  owner_t i_last,
    output owner_t o_winner,
    output logic   o_any
);

    owner_t w_winner;

    always_comb begin
        // NOTE: default first so every path assigns w_winner; otherwise a latch is inferred.
        w_winner = OWN_I;
        if (i_req_ic && i_req_dc) begin
            w_winner = RR_EN ? other_owner(i_last) : OWN_D;
        end else if (i_req_dc) begin
            w_winner = OWN_D;
        end
    end

    assign o_winner = w_winner;
    assign o_any    = i_req_ic | i_req_dc;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one slow line-wide memory port between the I-cache and the D-cache.
//   One requester is granted at a time; its read/write/address/write-line are
//   latched onto the memory port, the returned line is latched into that
//   requester's rdata register, and a one-cycle ready pulse completes the
//   transaction. An optional watchdog flags a transfer that never finishes.
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   i_read/i_write/i_addr/i_wdata   I-cache line request (held until i_ready)
//   i_rdata/i_ready                 I-cache returned line + completion pulse
//   d_read/d_write/d_addr/d_wdata   D-cache line request (held until d_ready)
//   d_rdata/d_ready                 D-cache returned line + completion pulse
//   mem_read/mem_write/mem_addr/mem_wdata   registered memory request
//   mem_rdata/mem_ready             memory response
//   grant_d                         1 while the D-cache owns the port (debug)
//   arb_timeout                     sticky watchdog flag
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter bit RR_EN   = 1'b1,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              grant_d,
    output logic              arb_timeout
);

    // Watchdog counter only needs to reach TIMEOUT, then it saturates.
    localparam int              CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_t             r_state;
    owner_t             r_owner;
    owner_t             r_last;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_i_rdata;
    logic [DATA_W-1:0]  r_d_rdata;
    logic               r_i_ready;
    logic               r_d_ready;
    logic               r_grant_d;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_wd_cnt;

    logic               w_req_i;
    logic               w_req_d;
    logic               w_any;
    owner_t             w_winner;
    logic               w_win_d;
    logic               w_sel_read;
    logic               w_sel_write;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [CNT_W-1:0]   w_wd_next;

    assign w_req_i = i_read | i_write;
    assign w_req_d = d_read | d_write;

    rr_pick2 #(
        .RR_EN (RR_EN)
    ) u_pick (
        .i_req_ic (w_req_i),
        .i_req_dc (w_req_d),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Winner's request fields, forwarded unchanged (read&write together is
    // passed through as-is).
    assign w_win_d     = (w_winner == OWN_D);
    assign w_sel_read  = w_win_d ? d_read  : i_read;
    assign w_sel_write = w_win_d ? d_write : i_write;
    assign w_sel_addr  = w_win_d ? d_addr  : i_addr;
    assign w_sel_wdata = w_win_d ? d_wdata : i_wdata;

    assign w_wd_next = (r_wd_cnt == TO_CNT) ? r_wd_cnt : r_wd_cnt + CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_I;
            r_last      <= OWN_I;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            // NOTE: the wide line registers are reset too, because every
            // output, returned lines included, must read 0 after reset.
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_grant_d   <= 1'b0;
            r_timeout   <= 1'b0;
            r_wd_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state     <= ST_BUSY;
                        r_owner     <= w_winner;
                        r_last      <= w_winner;
                        r_grant_d   <= w_win_d;
                        r_mem_read  <= w_sel_read;
                        r_mem_write <= w_sel_write;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_wd_cnt    <= '0;
                    end
                end

                ST_BUSY: begin
                    // Watchdog only observes; the transfer keeps waiting.
                    if (TIMEOUT > 0) begin
                        r_wd_cnt <= w_wd_next;
                        if (w_wd_next == TO_CNT) begin
                            r_timeout <= 1'b1;
                        end
                    end
                    if (mem_ready) begin
                        r_state     <= ST_DONE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (r_owner == OWN_D) begin
                            r_d_rdata <= mem_rdata;
                            r_d_ready <= 1'b1;
                        end else begin
                            r_i_rdata <= mem_rdata;
                            r_i_ready <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    // Requests seen here are ignored; the owner is still
                    // holding its request while it sees ready.
                    r_state   <= ST_IDLE;
                    r_i_ready <= 1'b0;
                    r_d_ready <= 1'b0;
                    r_grant_d <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_rdata     = r_i_rdata;
    assign i_ready     = r_i_ready;
    assign d_rdata     = r_d_rdata;
    assign d_ready     = r_d_ready;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign grant_d     = r_grant_d;
    assign arb_timeout = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Two arbiter instances: index 0 is round-robin with an 8-cycle watchdog,
//   index 1 is fixed priority (D wins) with the watchdog disabled. Directed
//   scenarios are followed by random request rounds; expectations come from a
//   transaction-level model (last grant, per-cache returned line, sticky flag).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n_s     [2];
    logic          i_read_s    [2];
    logic          i_write_s   [2];
    logic [AW-1:0] i_addr_s    [2];
    logic [DW-1:0] i_wdata_s   [2];
    logic          d_read_s    [2];
    logic          d_write_s   [2];
    logic [AW-1:0] d_addr_s    [2];
    logic [DW-1:0] d_wdata_s   [2];
    logic [DW-1:0] mem_rdata_s [2];
    logic          mem_ready_s [2];

    logic [DW-1:0] i_rdata_o   [2];
    logic          i_ready_o   [2];
    logic [DW-1:0] d_rdata_o   [2];
    logic          d_ready_o   [2];
    logic          mem_read_o  [2];
    logic          mem_write_o [2];
    logic [AW-1:0] mem_addr_o  [2];
    logic [DW-1:0] mem_wdata_o [2];
    logic          grant_d_o   [2];
    logic          arb_to_o    [2];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n_s[0]),
        .i_read(i_read_s[0]), .i_write(i_write_s[0]), .i_addr(i_addr_s[0]), .i_wdata(i_wdata_s[0]),
        .i_rdata(i_rdata_o[0]), .i_ready(i_ready_o[0]),
        .d_read(d_read_s[0]), .d_write(d_write_s[0]), .d_addr(d_addr_s[0]), .d_wdata(d_wdata_s[0]),
        .d_rdata(d_rdata_o[0]), .d_ready(d_ready_o[0]),
        .mem_read(mem_read_o[0]), .mem_write(mem_write_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata_s[0]), .mem_ready(mem_ready_s[0]),
        .grant_d(grant_d_o[0]), .arb_timeout(arb_to_o[0])
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n_s[1]),
        .i_read(i_read_s[1]), .i_write(i_write_s[1]), .i_addr(i_addr_s[1]), .i_wdata(i_wdata_s[1]),
        .i_rdata(i_rdata_o[1]), .i_ready(i_ready_o[1]),
        .d_read(d_read_s[1]), .d_write(d_write_s[1]), .d_addr(d_addr_s[1]), .d_wdata(d_wdata_s[1]),
        .d_rdata(d_rdata_o[1]), .d_ready(d_ready_o[1]),
        .mem_read(mem_read_o[1]), .mem_write(mem_write_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata_s[1]), .mem_ready(mem_ready_s[1]),
        .grant_d(grant_d_o[1]), .arb_timeout(arb_to_o[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 0;

    // Reference model state, per instance (owner: 0 = I, 1 = D).
    int            m_last [2];
    logic [DW-1:0] m_ird  [2];
    logic [DW-1:0] m_drd  [2];
    bit            m_to   [2];

    function automatic bit rr_of(input int s);
        return (s == 0);
    endfunction

    function automatic int to_of(input int s);
        return (s == 0) ? 8 : 0;
    endfunction

    function automatic logic [DW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (dut %0d): observed %h expected %h", tag, sel, obs, exp);
        end
    endtask

    // who: 0 = I, 1 = D; typ: 0 none, 1 read, 2 write, 3 read+write
    task automatic set_req(input int who, input int typ, input logic [AW-1:0] a, input logic [DW-1:0] w);
        if (who == 0) begin
            i_read_s[sel]  = typ[0];
            i_write_s[sel] = typ[1];
            i_addr_s[sel]  = a;
            i_wdata_s[sel] = w;
        end else begin
            d_read_s[sel]  = typ[0];
            d_write_s[sel] = typ[1];
            d_addr_s[sel]  = a;
            d_wdata_s[sel] = w;
        end
    endtask

    task automatic clear_inputs(input int s);
        i_read_s[s] = 1'b0; i_write_s[s] = 1'b0; i_addr_s[s] = '0; i_wdata_s[s] = '0;
        d_read_s[s] = 1'b0; d_write_s[s] = 1'b0; d_addr_s[s] = '0; d_wdata_s[s] = '0;
        mem_rdata_s[s] = '0; mem_ready_s[s] = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mem_read"},  mem_read_o[sel],  1'b0);
        check({tag, "_mem_write"}, mem_write_o[sel], 1'b0);
        check({tag, "_i_ready"},   i_ready_o[sel],   1'b0);
        check({tag, "_d_ready"},   d_ready_o[sel],   1'b0);
        check({tag, "_grant_d"},   grant_d_o[sel],   1'b0);
        check({tag, "_i_rdata"},   i_rdata_o[sel],   m_ird[sel]);
        check({tag, "_d_rdata"},   d_rdata_o[sel],   m_drd[sel]);
        check({tag, "_timeout"},   arb_to_o[sel],    m_to[sel]);
    endtask

    // Reset at one edge, verify every output is 0, then release.
    task automatic do_reset();
        rst_n_s[sel] = 1'b0;
        tick();
        m_last[sel] = 0; m_ird[sel] = '0; m_drd[sel] = '0; m_to[sel] = 1'b0;
        check("rst_mem_addr",  mem_addr_o[sel],  '0);
        check("rst_mem_wdata", mem_wdata_o[sel], '0);
        check_idle("rst");
        rst_n_s[sel] = 1'b1;
        clear_inputs(sel);
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check_idle("gap");
        end
    endtask

    // Serve one transaction starting from an IDLE cycle with at least one
    // request present. nb = BUSY cycles (mem_ready given in the last one).
    // perturb: change the owner's addr/wdata in BUSY; drop: owner drops its
    // request in BUSY; keep: owner keeps requesting after completion.
    task automatic serve(input int nb, input bit perturb, input bit drop, input bit keep);
        int            own;
        bit            ri, rd, to_exp;
        logic          er, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd, val;
        int            to;
        to = to_of(sel);
        ri = i_read_s[sel] | i_write_s[sel];
        rd = d_read_s[sel] | d_write_s[sel];
        if (ri && rd) own = rr_of(sel) ? (1 - m_last[sel]) : 1;
        else          own = rd ? 1 : 0;
        er  = own ? d_read_s[sel]  : i_read_s[sel];
        ew  = own ? d_write_s[sel] : i_write_s[sel];
        ea  = own ? d_addr_s[sel]  : i_addr_s[sel];
        ewd = own ? d_wdata_s[sel] : i_wdata_s[sel];
        val = rand_line();
        tick();
        for (int c = 1; c <= nb; c++) begin
            check("busy_mem_read",  mem_read_o[sel],  er);
            check("busy_mem_write", mem_write_o[sel], ew);
            check("busy_mem_addr",  mem_addr_o[sel],  ea);
            check("busy_mem_wdata", mem_wdata_o[sel], ewd);
            check("busy_grant_d",   grant_d_o[sel],   own[0]);
            check("busy_i_ready",   i_ready_o[sel],   1'b0);
            check("busy_d_ready",   d_ready_o[sel],   1'b0);
            check("busy_timeout",   arb_to_o[sel],    m_to[sel] | (to > 0 && c - 1 >= to));
            if (c == 1 && perturb) begin
                if (own == 1) begin d_addr_s[sel] = AW'($urandom); d_wdata_s[sel] = rand_line(); end
                else          begin i_addr_s[sel] = AW'($urandom); i_wdata_s[sel] = rand_line(); end
            end
            if (c == 1 && drop) set_req(own, 0, '0, '0);
            if (c == nb) begin
                mem_ready_s[sel] = 1'b1;
                mem_rdata_s[sel] = val;
            end
            tick();
        end
        mem_ready_s[sel] = 1'b0;
        mem_rdata_s[sel] = rand_line();
        // Completion cycle: only the owner pulses ready, with the returned line.
        to_exp = m_to[sel] | (to > 0 && nb >= to);
        if (own == 1) m_drd[sel] = val; else m_ird[sel] = val;
        check("done_i_ready",   i_ready_o[sel],   own == 0);
        check("done_d_ready",   d_ready_o[sel],   own == 1);
        check("done_i_rdata",   i_rdata_o[sel],   m_ird[sel]);
        check("done_d_rdata",   d_rdata_o[sel],   m_drd[sel]);
        check("done_mem_read",  mem_read_o[sel],  1'b0);
        check("done_mem_write", mem_write_o[sel], 1'b0);
        check("done_mem_addr",  mem_addr_o[sel],  ea);
        check("done_grant_d",   grant_d_o[sel],   own[0]);
        check("done_timeout",   arb_to_o[sel],    to_exp);
        m_to[sel]   = to_exp;
        m_last[sel] = own;
        tick();
        check_idle("post");
        if (!keep) set_req(own, 0, '0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "global timeout");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_n_s[s] = 1'b0;
            clear_inputs(s);
        end
        for (int s = 0; s < 2; s++) begin
            sel = s;
            do_reset();
        end

        // ---------------- round-robin instance, watchdog 8 ----------------
        sel = 0;
        // Single D read, memory answers in the third strobe cycle.
        set_req(1, 1, 28'h0000010, rand_line());
        serve(3, 1'b0, 1'b0, 1'b0);
        idle_ticks(1);

        // From reset, I read and D write together: D first, then I.
        do_reset();
        set_req(0, 1, AW'($urandom), rand_line());
        set_req(1, 2, AW'($urandom), rand_line());
        check("tie_first_is_d", d_read_s[sel] | d_write_s[sel], 1'b1);
        serve(2, 1'b0, 1'b0, 1'b0);
        serve(2, 1'b0, 1'b0, 1'b0);
        idle_ticks(1);

        // D write with a fixed line; inputs change during BUSY.
        set_req(1, 2, 28'hABCDEF1, 128'hDEAD0000_11112222_33334444_0000BEEF);
        serve(3, 1'b1, 1'b0, 1'b0);

        // Owner drops its request mid-transfer; zero extra memory latency.
        set_req(0, 1, AW'($urandom), rand_line());
        serve(1, 1'b0, 1'b1, 1'b0);
        idle_ticks(2);

        // Reset in the middle of a transfer, with mem_ready arriving.
        set_req(0, 2, AW'($urandom), rand_line());
        tick();
        check("pre_rst_mem_write", mem_write_o[sel], 1'b1);
        tick();
        mem_ready_s[sel] = 1'b1;
        mem_rdata_s[sel] = rand_line();
        do_reset();
        tick();
        check_idle("after_rst");
        set_req(1, 1, AW'($urandom), rand_line());
        serve(2, 1'b0, 1'b0, 1'b0);

        // Watchdog: 12 BUSY cycles, flag visible after the 8th, then sticky.
        set_req(0, 1, AW'($urandom), rand_line());
        serve(12, 1'b0, 1'b0, 1'b0);
        set_req(1, 2, AW'($urandom), rand_line());
        serve(2, 1'b0, 1'b0, 1'b0);

        // ---------------- fixed-priority instance, no watchdog ----------------
        sel = 1;
        set_req(0, 1, AW'($urandom), rand_line());
        set_req(1, 2, AW'($urandom), rand_line());
        for (int k = 0; k < 3; k++) serve(1 + k, 1'b0, 1'b0, 1'b1);
        serve(2, 1'b0, 1'b0, 1'b0);
        serve(2, 1'b0, 1'b0, 1'b0);
        set_req(1, 1, AW'($urandom), rand_line());
        serve(12, 1'b0, 1'b0, 1'b0);

        // ---------------- random rounds on both instances ----------------
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int r = 0; r < 40; r++) begin
                int ti, td, t;
                t  = $urandom_range(0, 9);
                ti = (t < 5) ? 1 : (t < 9) ? 2 : 3;
                t  = $urandom_range(0, 9);
                td = (t < 5) ? 1 : (t < 9) ? 2 : 3;
                case ($urandom_range(0, 2))
                    0:       ti = 0;
                    1:       td = 0;
                    default: ;
                endcase
                set_req(0, ti, AW'($urandom), rand_line());
                set_req(1, td, AW'($urandom), rand_line());
                while (i_read_s[sel] | i_write_s[sel] | d_read_s[sel] | d_write_s[sel])
                    serve($urandom_range(1, 6), 1'($urandom), 1'($urandom), 1'b0);
                idle_ticks($urandom_range(0, 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
